// File: rtl/mem_stage_pkg.sv
// Shared pipeline package: bus widths, field offsets and packed views of the
// EXE->MEM, MEM->WB and MEM forwarding buses.
package mem_stage_pkg;

  localparam int ES_MS_BUS_W = 71;
  localparam int MS_WS_BUS_W = 70;
  localparam int FWD_BUS_W   = 38;

  // es_ms_bus field offsets
  localparam int ES_PC_LSB    = 39;
  localparam int ES_PC_MSB    = 70;
  localparam int ES_GR_WE     = 38;
  localparam int ES_DEST_LSB  = 33;
  localparam int ES_DEST_MSB  = 37;
  localparam int ES_ALU_LSB   = 1;
  localparam int ES_ALU_MSB   = 32;
  localparam int ES_RFM       = 0;

  // ms_ws_bus field offsets
  localparam int MS_PC_LSB    = 38;
  localparam int MS_PC_MSB    = 69;
  localparam int MS_GR_WE     = 37;
  localparam int MS_DEST_LSB  = 32;
  localparam int MS_DEST_MSB  = 36;
  localparam int MS_RES_LSB   = 0;
  localparam int MS_RES_MSB   = 31;

  // ms_fwd_bus field offsets
  localparam int FWD_WE       = 37;
  localparam int FWD_DEST_LSB = 32;
  localparam int FWD_DEST_MSB = 36;
  localparam int FWD_DATA_LSB = 0;
  localparam int FWD_DATA_MSB = 31;

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic        res_from_mem;
  } es_ms_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
  } ms_ws_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] data;
  } fwd_t;

  function automatic logic [31:0] sel_result(input logic rfm, input logic [31:0] ld,
                                             input logic [31:0] alu);
    return rfm ? ld : alu;
  endfunction

endpackage

// File: rtl/mem_stage_rdata_hold.sv
// Read-data hold for the MEM stage: the synchronous RAM only shows an
// instruction's load data in its first MEM cycle, so a stall must capture it.
module ms_rdata_hold (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_accept,
  input  logic        i_stall,
  input  logic        i_drain,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_load_data
);

  logic        r_first_cycle;
  logic        r_buf_valid;
  logic [31:0] r_rdata_buf;

  always_ff @(posedge clk) begin
    if (reset) r_first_cycle <= 1'b0;
    else       r_first_cycle <= i_accept;
  end

  // Capture and accept are mutually exclusive: a stall blocks acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
      r_rdata_buf <= 32'h0;
    end else if (i_accept || i_drain) begin
      r_buf_valid <= 1'b0;
    end else if (r_first_cycle && i_stall) begin
      r_buf_valid <= 1'b1;
      r_rdata_buf <= i_rdata;
    end
  end

  assign o_load_data = r_buf_valid ? r_rdata_buf : i_rdata;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: one-entry register between EXE and WB, load-result
// select and forwarding source for decode.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   es_to_ms_valid,
  input  logic [ES_MS_BUS_W-1:0] es_ms_bus,
  output logic                   ms_allow_in,
  input  logic                   ws_allow_in,
  output logic                   ms_to_ws_valid,
  output logic [MS_WS_BUS_W-1:0] ms_ws_bus,
  input  logic [31:0]            data_sram_rdata,
  output logic [FWD_BUS_W-1:0]   ms_fwd_bus
);

  logic        r_ms_valid;
  es_ms_t      r_pl;
  es_ms_t      w_es;
  ms_ws_t      w_ws;
  fwd_t        w_fwd;
  logic        w_ready_go;
  logic        w_accept;
  logic        w_leave;
  logic [31:0] w_load_data;
  logic [31:0] w_final;

  assign w_es        = es_ms_t'(es_ms_bus);
  assign w_ready_go  = 1'b1;
  assign ms_allow_in = !r_ms_valid || (w_ready_go && ws_allow_in);
  assign w_accept    = es_to_ms_valid && ms_allow_in;
  assign w_leave     = r_ms_valid && w_ready_go && ws_allow_in;

  always_ff @(posedge clk) begin
    if (reset)            r_ms_valid <= 1'b0;
    else if (ms_allow_in) r_ms_valid <= es_to_ms_valid;
  end

  always_ff @(posedge clk) begin
    if (reset)         r_pl <= '0;
    else if (w_accept) r_pl <= w_es;
  end

  ms_rdata_hold u_hold (
    .clk         (clk),
    .reset       (reset),
    .i_accept    (w_accept),
    .i_stall     (r_ms_valid && !ws_allow_in),
    .i_drain     (w_leave && !w_accept),
    .i_rdata     (data_sram_rdata),
    .o_load_data (w_load_data)
  );

  assign w_final = sel_result(r_pl.res_from_mem, w_load_data, r_pl.alu_result);

  always_comb begin
    w_ws              = '0;
    w_ws.pc           = r_pl.pc;
    w_ws.gr_we        = r_pl.gr_we;
    w_ws.dest         = r_pl.dest;
    w_ws.final_result = w_final;
  end

  // Only the write-enable is qualified; dest/data may show stale payload.
  always_comb begin
    w_fwd      = '0;
    w_fwd.we   = r_ms_valid && r_pl.gr_we;
    w_fwd.dest = r_pl.dest;
    w_fwd.data = w_final;
  end

  assign ms_to_ws_valid = r_ms_valid;
  assign ms_ws_bus      = w_ws;
  assign ms_fwd_bus     = w_fwd;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a transaction model pushes the expected WB
// payload when an instruction's load data is presented; transfers pop it.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid;
  logic [70:0] es_ms_bus;
  logic        ms_allow_in;
  logic        ws_allow_in;
  logic        ms_to_ws_valid;
  logic [69:0] ms_ws_bus;
  logic [31:0] data_sram_rdata;
  logic [37:0] ms_fwd_bus;

  int n_cmp = 0;
  int n_err = 0;

  logic [69:0] sb[$];

  // bench model of the stage
  logic        m_valid, m_first, m_we, m_rfm;
  logic [31:0] m_pc, m_alu, m_final;
  logic [4:0]  m_dest;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_ms_bus       (es_ms_bus),
    .ms_allow_in     (ms_allow_in),
    .ws_allow_in     (ws_allow_in),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_ws_bus       (ms_ws_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_fwd_bus      (ms_fwd_bus)
  );

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 1'b0; m_first = 1'b0; m_we = 1'b0; m_rfm = 1'b0;
    m_pc = '0; m_alu = '0; m_final = '0; m_dest = '0;
    sb.delete();
  endtask

  // One cycle: drive inputs, check combinational outputs, advance on posedge.
  task automatic tick(input logic v, input logic [31:0] pc, input logic we,
                      input logic [4:0] dst, input logic [31:0] alu, input logic rfm,
                      input logic wsa, input logic [31:0] rd);
    logic acc;
    logic [69:0] exp;
    es_to_ms_valid  = v;
    es_ms_bus       = {pc, we, dst, alu, rfm};
    ws_allow_in     = wsa;
    data_sram_rdata = rd;
    #2;
    if (m_first) begin
      m_final = m_rfm ? rd : m_alu;
      sb.push_back({m_pc, m_we, m_dest, m_final});
    end
    chk("allow_in", 70'(ms_allow_in), 70'(!m_valid || wsa));
    chk("to_ws_valid", 70'(ms_to_ws_valid), 70'(m_valid));
    chk("fwd_we", 70'(ms_fwd_bus[37]), 70'(m_valid && m_we));
    if (m_valid) begin
      chk("fwd_dest", 70'(ms_fwd_bus[36:32]), 70'(m_dest));
      chk("fwd_data", 70'(ms_fwd_bus[31:0]), 70'(m_final));
      if (wsa) begin
        if (sb.size() == 0) chk("sb_underflow", 70'(1), 70'(0));
        else begin
          exp = sb.pop_front();
          chk("ws_bus", ms_ws_bus, exp);
        end
      end
    end
    @(posedge clk); #1;
    acc = v && (!m_valid || wsa);
    if (!m_valid || wsa) m_valid = v;
    m_first = acc;
    if (acc) begin
      m_pc = pc; m_we = we; m_dest = dst; m_alu = alu; m_rfm = rfm;
    end
  endtask

  task automatic rst_cycle(input logic v);
    reset = 1'b1;
    es_to_ms_valid = v;
    es_ms_bus = {32'h1c00_0f00, 1'b1, 5'd3, 32'h5555_0000, 1'b1};
    ws_allow_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    es_to_ms_valid = 1'b0;
    model_clear();
    #1;
    chk("rst_valid", 70'(ms_to_ws_valid), 70'(0));
    chk("rst_allow", 70'(ms_allow_in), 70'(1));
    chk("rst_ws_bus", ms_ws_bus, 70'(0));
    chk("rst_fwd", 70'(ms_fwd_bus), 70'(0));
    chk("rst_buf_valid", 70'(dut.u_hold.r_buf_valid), 70'(0));
  endtask

  initial begin
    reset = 1'b1; es_to_ms_valid = 1'b0; es_ms_bus = '0;
    ws_allow_in = 1'b1; data_sram_rdata = '0;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    ws_allow_in = 1'b0;
    rst_cycle(1'b0);

    // ALU pass-through
    tick(1, 32'h1c00_0000, 1, 5'd5, 32'h1234_5678, 0, 1, 32'hcafe_0001);
    tick(0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 32'hcafe_0002);
    // load, no stall
    tick(1, 32'h1c00_0010, 1, 5'd7, 32'h1111_1111, 1, 1, 32'h0);
    tick(0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 32'hdead_beef);
    tick(0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 32'h0);
    // load with 3-cycle stall; a waiting EXE entry must not get in
    tick(1, 32'h1c00_0020, 1, 5'd9, 32'h2222_2222, 1, 1, 32'h0);
    tick(1, 32'h1c00_0bad, 1, 5'd1, 32'hbad0_bad0, 0, 0, 32'haaaa_5555);
    tick(1, 32'h1c00_0bad, 1, 5'd1, 32'hbad0_bad0, 0, 0, 32'h0000_0000);
    tick(1, 32'h1c00_0bad, 1, 5'd1, 32'hbad0_bad0, 0, 0, 32'hffff_ffff);
    tick(0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 32'h1357_9bdf);
    tick(0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 32'h0);
    // back-to-back, no bubbles
    tick(1, 32'h0, 1, 5'd1, 32'h0000_00a0, 0, 1, 32'h0);
    tick(1, 32'h4, 1, 5'd2, 32'h0000_00a4, 1, 1, 32'h0);
    tick(1, 32'h8, 0, 5'd3, 32'h0000_00a8, 0, 1, 32'h0bad_f00d);
    tick(1, 32'hc, 1, 5'd4, 32'h0000_00ac, 0, 1, 32'h0);
    tick(0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 32'h0);
    // bubble with gr_we on the bus
    tick(0, 32'h1c00_0040, 1, 5'd12, 32'h7777_7777, 0, 1, 32'h0);
    tick(0, 32'h1c00_0040, 1, 5'd12, 32'h7777_7777, 0, 0, 32'h0);
    // reset in the middle of a stalled load, with an entrant waiting
    tick(1, 32'h1c00_0050, 1, 5'd10, 32'h3333_3333, 1, 1, 32'h0);
    tick(0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 32'haaaa_5555);
    tick(0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 32'h0);
    rst_cycle(1'b1);
    tick(0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 32'h0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      tick(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 5'($urandom),
           $urandom, 1'($urandom), 1'($urandom_range(0, 2) != 0), $urandom);
    end
    tick(0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 32'h0);
    chk("sb_empty", 70'(sb.size()), 70'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; all widths fixed by the shared pipeline package.
REQ-002 clk  in  1  pipeline clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 es_to_ms_valid  in  1  EXE holds a valid instruction for MEM.
REQ-005 es_ms_bus  in  71  {pc[70:39], gr_we[38], dest[37:33], alu_result[32:1], res_from_mem[0]}.
REQ-006 ms_allow_in  out  1  MEM can accept an instruction this cycle.
REQ-007 ws_allow_in  in  1  WB can accept an instruction this cycle.
REQ-008 ms_to_ws_valid  out  1  MEM presents a valid instruction to WB.
REQ-009 ms_ws_bus  out  70  {pc[69:38], gr_we[37], dest[36:32], final_result[31:0]}.
REQ-010 data_sram_rdata  in  32  synchronous data RAM read data; valid exactly one cycle after EXE presented the address.
REQ-011 ms_fwd_bus  out  38  {we[37], dest[36:32], data[31:0]}; forwarding source for decode.

Function
REQ-012 ms_valid SHALL load es_to_ms_valid on every posedge where ms_allow_in=1.
REQ-013 Payload registers (pc, gr_we, dest, alu_result, res_from_mem) SHALL load from es_ms_bus only when es_to_ms_valid && ms_allow_in.
REQ-014 ms_ready_go SHALL be 1; ms_allow_in = !ms_valid || ws_allow_in; ms_to_ws_valid = ms_valid.
REQ-015 first_cycle flag SHALL be set on acceptance and cleared on the next posedge.
REQ-016 In first_cycle, load data SHALL come directly from data_sram_rdata.
REQ-017 If first_cycle and ms_to_ws_valid && !ws_allow_in, the cycle's data_sram_rdata SHALL be captured into rdata_buf and buf_valid set; while buf_valid=1, load data SHALL come from rdata_buf. Later RAM outputs reflect younger EXE addresses and SHALL be ignored.
REQ-018 buf_valid SHALL clear when MEM accepts a new instruction or when the held instruction leaves with no replacement.
REQ-019 final_result = res_from_mem ? load_data : alu_result, full 32-bit word, no extension.
REQ-020 ms_fwd_bus.we = ms_valid && gr_we. dest and data SHALL be the current dest and final_result. Both SHALL be combinationally valid in the same cycle, including first_cycle loads.
REQ-021 Simultaneous leave and enter (ms_valid, ws_allow_in, es_to_ms_valid all 1) SHALL replace the payload with no bubble.
REQ-022 Leave with no entrant SHALL drop ms_valid to 0 at the next posedge.
REQ-023 When ms_valid=0, ms_fwd_bus.we SHALL be 0 regardless of payload contents.

Reset
REQ-024 On reset: ms_valid=0, first_cycle=0, buf_valid=0, rdata_buf=0, and all payload registers 0.
REQ-025 Outputs after reset: ms_allow_in=1, ms_to_ws_valid=0, ms_ws_bus=0, ms_fwd_bus=0.
REQ-026 Reset mid-stall SHALL discard the held instruction and buffered data; reset has priority over acceptance in the same cycle.

Structure
REQ-027 The shared pipeline package SHALL hold ES_MS_BUS_W=71, MS_WS_BUS_W=70, FWD_BUS_W=38, and field offset constants for all three buses.
REQ-028 The read-data hold logic (first_cycle, buf_valid, rdata_buf, load-data mux) SHALL be one sub-module, ms_rdata_hold. Everything else stays flat in mem_stage.

Verification
REQ-029 ALU op pass-through: accept {pc=0x1c000000, gr_we=1, dest=5, alu=0x12345678, rfm=0} with ws_allow_in=1 -> next cycle ms_ws_bus.final_result=0x12345678, ms_fwd_bus={1,5,0x12345678}.
REQ-030 Load, no stall: rfm=1, rdata=0xDEADBEEF in first_cycle -> final_result=0xDEADBEEF in that same cycle.
REQ-031 Load with stall: ws_allow_in=0 for 3 cycles; rdata=0xAAAA5555 in first_cycle, then 0x0 and 0xFFFFFFFF -> final_result stays 0xAAAA5555; ms_allow_in=0 throughout the stall.
REQ-032 Back-to-back: ws_allow_in=1 and es_to_ms_valid=1 for 4 cycles with pc 0x0,0x4,0x8,0xC -> ms_to_ws_valid=1 every cycle, pc follows in order with one-cycle latency, no bubbles.
REQ-033 Reset during REQ-031 stall -> next cycle ms_valid=0, ms_to_ws_valid=0, ms_fwd_bus.we=0, ms_allow_in=1, buf_valid=0.
REQ-034 Bubble: es_to_ms_valid=0 with gr_we=1 still on es_ms_bus -> ms_fwd_bus.we=0, ms_to_ws_valid=0.
